pipeline_mips: RTL and testbench
================================

Name: pipeline_mips

Overview:
- 5-stage in-order MIPS subset core (IF/ID/EX/MEM/WB) with an on-chip 512-word data memory protected by a SEC-DED (39,32) Hamming code.
- Instructions come from an external combinational instruction memory indexed by pc.
- A user port gives bench/host access to data memory.
- An error-injection port overwrites stored data or check bits without re-encoding. Single errors are corrected on load; a double error halts the core permanently until reset.

Parameters:
- DMEM_WORDS, 512, data memory depth in words; memory index is 9 bits.
- RESET_PC, 32'h0, pc value after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- pc  out  32  fetch address, byte address, word-aligned.
- instruction  in  32  instruction at pc, valid in the same cycle.
- user_addr  in  13  user word address; only [8:0] are used.
- user_we  in  1  user write enable.
- user_din  in  32  user write data; stored with freshly encoded check bits.
- user_dout  out  32 signed  corrected data at user_addr, combinational.
- error_dwe  in  1  raw write of error_din into the data array.
- error_pwe  in  1  raw write of error_pin into the check array.
- error_din  in  32  injected data word.
- error_pin  in  7  injected check bits.
- error_addr  in  9  injection word index.

Behaviour:
- ISA:
  - ADDI: opcode 001000, rt = rs + sext(imm).
  - R-type: opcode 000000, ADD funct 100000, SUB funct 100010, rd = rs op rt.
  - LW: opcode 100011.
  - SW: opcode 101011.
  - NOP is 32'h0. Any other encoding executes as NOP.
  - Arithmetic wraps mod 2^32; no overflow trap.
- Data address = rs + sext(imm). Word index = address[10:2]; upper bits are ignored.
- pc: advances by +4 every cycle unless stalled. No branches.
- Register file: 32x32, R0 reads as 0 and ignores writes. A WB write is visible to an ID read in the same cycle (internal bypass).
- Forwarding: EX/MEM and MEM/WB results forward to EX operands; EX/MEM has priority.
- Load-use hazard: LW followed by a consumer of its rt stalls IF/ID for 1 cycle and inserts a bubble in EX.
- Memory access:
  - SW writes the data plus encode(data) at the MEM-stage posedge.
  - LW reads and decodes combinationally in MEM; the corrected value is registered into MEM/WB.
- SEC-DED encoding:
  - Codeword positions 1..38. Check bits c[5:0] sit at positions 1, 2, 4, 8, 16, 32. Data bits d0..d31 fill the remaining positions in ascending order (d0 at position 3).
  - c[i] = XOR of the data bits whose position has bit i set.
  - c[6] = XOR of all 32 data bits and c[5:0] (overall parity).
- SEC-DED decoding:
  - Syndrome s = recomputed c[5:0] XOR stored c[5:0]. Overall o = XOR of all 39 stored bits.
  - s=0, o=0: clean.
  - o=1: single error. If s maps to a data position, flip that data bit; otherwise the data is already correct.
  - s!=0, o=0: double error (DED).
  - Memory is never scrubbed.
- DED on an LW in MEM:
  - A sticky halt flag sets at that posedge.
  - The faulting load does not write back.
  - From then on, pc and all pipeline registers are frozen and no register or memory writes occur. Instructions younger than the load never complete.
  - An instruction already in WB at that edge completes.
- Write priority per address in one cycle: error injection > user write > pipeline SW. error_dwe and error_pwe operate independently, and both may be set.
- Memory arrays power up all-zero (a valid codeword) and are not affected by rst.
- Reset (rst=0, asynchronous):
  - pc = RESET_PC.
  - Pipeline registers hold NOPs.
  - Register file cleared.
  - Halt flag cleared.
  - user_dout reflects memory only.
  - Reset in mid-run discards in-flight instructions; their stores are not performed.

Decomposition:
- Package pipeline_mips_pkg: opcode/funct constants, NOP, the data-position-to-codeword-position map, and the encode function.
- One sub-module pipeline_mips_secded: combinational decoder with inputs data[31:0] and chk[6:0], outputs corrected[31:0], sec, ded.
- It is instantiated twice: once for the MEM load path and once for user_dout.

Test Plan:
- Basic store: ADDI R1,R0,5; SW R1,4(R0); NOPs -> user_addr=1 gives user_dout=5.
- Forwarding: ADDI R1,R0,3; ADD R2,R1,R1; SUB R3,R2,R1; SW R2,0(R0); SW R3,8(R0) -> M[0]=6, M[2]=3.
- Load-use stall: user writes M[4]=7; LW R1,16(R0); ADD R2,R1,R1; SW R2,20(R0) -> M[5]=14; pc holds for exactly 1 cycle.
- SEC:
  - Data error: SW 2 to M[1], then inject error_dwe data 3 at index 1; LW R5,4(R0); SW R5,12(R0) -> M[3]=2.
  - Check error: M[8] holds 9; error_pwe flips one bit of its check bits; load and store elsewhere -> 9.
- DED: M[9]=4; inject error_dwe=error_pwe=1 at index 9 with data 5 and one flipped c bit; LW R1,36(R0), followed by ADDI R1..R4 and SW to M[10]=8 -> pc frozen, M[10] stays 0, and loading M[9] never completes.
- Reset mid-run: assert rst low during an instruction stream -> pc=0 immediately (asynchronous); M unchanged; a fresh program runs correctly after rst returns high.

Source files
------------

// File: rtl/pipeline_mips_pkg.sv
// Shared ISA constants, pipeline register layouts and the SEC-DED (39,32) encoder
// for the pipeline_mips core.
package pipeline_mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    typedef enum logic {ALU_ADD = 1'b0, ALU_SUB = 1'b1} alu_op_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        alu_op_e     alu_op;
        logic        use_imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
    } idex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] store_data;
    } exmem_t;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  dest;
        logic [31:0] data;
    } memwb_t;

    // Codeword position of data bit idx: the idx-th non-power-of-two in 3..38.
    function automatic logic [5:0] data_pos(input int idx);
        int         cnt;
        logic [5:0] pos;
        cnt = 0;
        pos = '0;
        for (int p = 3; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) pos = 6'(p);
                cnt++;
            end
        end
        return pos;
    endfunction

    function automatic logic [5:0] hamming_checks(input logic [31:0] d);
        logic [5:0] c;
        logic [5:0] pos;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            pos = data_pos(i);
            for (int b = 0; b < 6; b++) begin
                if (pos[b]) c[b] = c[b] ^ d[i];
            end
        end
        return c;
    endfunction

    function automatic logic [6:0] secded_encode(input logic [31:0] d);
        logic [5:0] c;
        c = hamming_checks(d);
        return {(^d) ^ (^c), c};
    endfunction

endpackage

// File: rtl/pipeline_mips_secded.sv
// Combinational SEC-DED (39,32) decoder: corrects single errors, flags double errors.
module pipeline_mips_secded
    import pipeline_mips_pkg::*;
(
    input  logic [31:0] data,
    input  logic [6:0]  chk,
    output logic [31:0] corrected,
    output logic        sec,
    output logic        ded
);

    logic [5:0] syndrome;
    logic       overall;

    assign syndrome = hamming_checks(data) ^ chk[5:0];
    assign overall  = (^data) ^ (^chk);
    assign sec      = overall;
    assign ded      = !overall && (syndrome != 6'd0);

    // A syndrome pointing at a check position leaves the data untouched.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_fix
            localparam logic [5:0] POS = data_pos(gi);
            assign corrected[gi] = data[gi] ^ (overall && (syndrome == POS));
        end
    endgenerate

endmodule

// File: rtl/pipeline_mips.sv
// 5-stage in-order MIPS subset (ADDI/ADD/SUB/LW/SW) with forwarding, load-use stall
// and a SEC-DED protected data memory that halts the core on an uncorrectable load.
module pipeline_mips
    import pipeline_mips_pkg::*;
#(
    parameter int          DMEM_WORDS = 512,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [31:0]        pc,
    input  logic [31:0]        instruction,
    input  logic [12:0]        user_addr,
    input  logic               user_we,
    input  logic [31:0]        user_din,
    output logic signed [31:0] user_dout,
    input  logic               error_dwe,
    input  logic               error_pwe,
    input  logic [31:0]        error_din,
    input  logic [6:0]         error_pin,
    input  logic [8:0]         error_addr
);

    logic [31:0] pc_q;
    logic [31:0] ifid_q;
    idex_t       idex_q, id_d;
    exmem_t      exmem_q, ex_d;
    memwb_t      memwb_q, mem_d;
    logic        halt_q;
    logic [31:0] rf_q [32];

    logic [31:0] dmem_data [DMEM_WORDS];
    logic [6:0]  dmem_chk  [DMEM_WORDS];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs_f, rt_f, rd_f;
    logic [31:0] rs_rd, rt_rd;
    logic        uses_rs, uses_rt, load_use;
    logic        wb_we, fault, freeze, core_we;
    logic [31:0] fwd_a, fwd_b, op_b;
    logic [8:0]  mem_idx, user_idx;
    logic [31:0] mem_rdata, user_rdata;
    logic        mem_sec, mem_ded, user_sec, user_ded;

    assign pc = pc_q;

    // ---------------- ID ----------------
    assign opcode = ifid_q[31:26];
    assign rs_f   = ifid_q[25:21];
    assign rt_f   = ifid_q[20:16];
    assign rd_f   = ifid_q[15:11];
    assign funct  = ifid_q[5:0];

    assign wb_we = memwb_q.reg_write && (memwb_q.dest != 5'd0) && !halt_q;
    assign rs_rd = (rs_f == 5'd0) ? 32'd0 :
                   (wb_we && memwb_q.dest == rs_f) ? memwb_q.data : rf_q[rs_f];
    assign rt_rd = (rt_f == 5'd0) ? 32'd0 :
                   (wb_we && memwb_q.dest == rt_f) ? memwb_q.data : rf_q[rt_f];

    always_comb begin
        id_d        = '0;
        uses_rs     = 1'b0;
        uses_rt     = 1'b0;
        id_d.rs     = rs_f;
        id_d.rt     = rt_f;
        id_d.rs_val = rs_rd;
        id_d.rt_val = rt_rd;
        id_d.imm    = {{16{ifid_q[15]}}, ifid_q[15:0]};
        case (opcode)
            OP_ADDI: begin
                id_d.reg_write = 1'b1;
                id_d.dest      = rt_f;
                id_d.use_imm   = 1'b1;
                uses_rs        = 1'b1;
            end
            OP_LW: begin
                id_d.reg_write = 1'b1;
                id_d.mem_read  = 1'b1;
                id_d.dest      = rt_f;
                id_d.use_imm   = 1'b1;
                uses_rs        = 1'b1;
            end
            OP_SW: begin
                id_d.mem_write = 1'b1;
                id_d.use_imm   = 1'b1;
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
            end
            OP_RTYPE: begin
                if (funct == FN_ADD || funct == FN_SUB) begin
                    id_d.reg_write = 1'b1;
                    id_d.dest      = rd_f;
                    id_d.alu_op    = (funct == FN_SUB) ? ALU_SUB : ALU_ADD;
                    uses_rs        = 1'b1;
                    uses_rt        = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign load_use = idex_q.mem_read && (idex_q.dest != 5'd0) &&
                      ((uses_rs && rs_f == idex_q.dest) || (uses_rt && rt_f == idex_q.dest));

    // ---------------- EX ----------------
    // Load results are not forwarded from EX/MEM; the load-use stall covers that case.
    always_comb begin
        fwd_a = idex_q.rs_val;
        fwd_b = idex_q.rt_val;
        if (memwb_q.reg_write && memwb_q.dest != 5'd0) begin
            if (memwb_q.dest == idex_q.rs) fwd_a = memwb_q.data;
            if (memwb_q.dest == idex_q.rt) fwd_b = memwb_q.data;
        end
        if (exmem_q.reg_write && !exmem_q.mem_read && exmem_q.dest != 5'd0) begin
            if (exmem_q.dest == idex_q.rs) fwd_a = exmem_q.alu;
            if (exmem_q.dest == idex_q.rt) fwd_b = exmem_q.alu;
        end
    end

    assign op_b = idex_q.use_imm ? idex_q.imm : fwd_b;

    always_comb begin
        ex_d            = '0;
        ex_d.reg_write  = idex_q.reg_write;
        ex_d.mem_read   = idex_q.mem_read;
        ex_d.mem_write  = idex_q.mem_write;
        ex_d.dest       = idex_q.dest;
        ex_d.store_data = fwd_b;
        ex_d.alu        = (idex_q.alu_op == ALU_SUB) ? (fwd_a - op_b) : (fwd_a + op_b);
    end

    // ---------------- MEM ----------------
    assign mem_idx  = exmem_q.alu[10:2];
    assign user_idx = user_addr[8:0];

    pipeline_mips_secded u_dec_mem (
        .data      (dmem_data[mem_idx]),
        .chk       (dmem_chk[mem_idx]),
        .corrected (mem_rdata),
        .sec       (mem_sec),
        .ded       (mem_ded)
    );

    pipeline_mips_secded u_dec_user (
        .data      (dmem_data[user_idx]),
        .chk       (dmem_chk[user_idx]),
        .corrected (user_rdata),
        .sec       (user_sec),
        .ded       (user_ded)
    );

    assign user_dout = user_rdata;
    assign fault     = exmem_q.mem_read && mem_ded && !halt_q;
    assign freeze    = halt_q || fault;
    assign core_we   = exmem_q.mem_write && !halt_q;

    always_comb begin
        mem_d           = '0;
        mem_d.reg_write = exmem_q.reg_write;
        mem_d.dest      = exmem_q.dest;
        mem_d.data      = exmem_q.mem_read ? mem_rdata : exmem_q.alu;
    end

    // Later assignments win: injection over user write over pipeline store.
    always_ff @(posedge clk) begin
        if (core_we) begin
            dmem_data[mem_idx] <= exmem_q.store_data;
            dmem_chk[mem_idx]  <= secded_encode(exmem_q.store_data);
        end
        if (user_we) begin
            dmem_data[user_idx] <= user_din;
            dmem_chk[user_idx]  <= secded_encode(user_din);
        end
        if (error_dwe) dmem_data[error_addr] <= error_din;
        if (error_pwe) dmem_chk[error_addr]  <= error_pin;
    end

    // ---------------- pipeline state ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            ifid_q  <= NOP;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            if (fault) halt_q <= 1'b1;
            if (!freeze) begin
                if (load_use) begin
                    idex_q <= '0;
                end else begin
                    pc_q   <= pc_q + 32'd4;
                    ifid_q <= instruction;
                    idex_q <= id_d;
                end
                exmem_q <= ex_d;
                memwb_q <= mem_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (wb_we) begin
            rf_q[memwb_q.dest] <= memwb_q.data;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{user_addr[12:9], exmem_q.alu[31:11], exmem_q.alu[1:0],
                           ifid_q[10:6], mem_sec, user_sec, user_ded};

endmodule

// File: tb/tb_pipeline_mips.sv
// Directed bench for pipeline_mips: stores, forwarding, load-use stall, SEC/DED, async reset.
module tb_pipeline_mips;

    logic               clk;
    logic               rst;
    logic [31:0]        pc;
    logic [31:0]        instruction;
    logic [12:0]        user_addr;
    logic               user_we;
    logic [31:0]        user_din;
    logic signed [31:0] user_dout;
    logic               error_dwe;
    logic               error_pwe;
    logic [31:0]        error_din;
    logic [6:0]         error_pin;
    logic [8:0]         error_addr;

    logic [31:0] imem [64];
    int n_cmp = 0;
    int n_bad = 0;
    int unsigned pc_exp [6] = '{4, 8, 8, 12, 16, 20};

    pipeline_mips dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .instruction (instruction),
        .user_addr   (user_addr),
        .user_we     (user_we),
        .user_din    (user_din),
        .user_dout   (user_dout),
        .error_dwe   (error_dwe),
        .error_pwe   (error_pwe),
        .error_din   (error_din),
        .error_pin   (error_pin),
        .error_addr  (error_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instruction = (pc[31:8] == 24'd0 && pc[1:0] == 2'd0) ? imem[pc[7:2]] : 32'h0;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
        return enc_i(6'b001000, rs, rt, imm);
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
        return enc_i(6'b100011, rs, rt, imm);
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
        return enc_i(6'b101011, rs, rt, imm);
    endfunction
    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    // Builds the full 38-bit codeword, then takes parities over it.
    function automatic logic [6:0] tb_encode(input logic [31:0] d);
        logic [38:0] cw;
        logic [6:0]  c;
        int          k;
        cw = '0;
        k  = 0;
        for (int p = 1; p <= 38; p++) begin
            if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16 && p != 32) begin
                cw[p] = d[k];
                k++;
            end
        end
        c = '0;
        for (int i = 0; i < 6; i++)
            for (int p = 1; p <= 38; p++)
                if (((p >> i) & 1) == 1) c[i] = c[i] ^ cw[p];
        c[6] = (^cw) ^ (^c[5:0]);
        return c;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic check_mem(input string tag, input int idx, input logic [31:0] exp);
        user_addr = 13'(idx);
        #1;
        check_eq(tag, user_dout, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic user_write(input int idx, input logic [31:0] d);
        user_addr = 13'(idx);
        user_din  = d;
        user_we   = 1'b1;
        @(negedge clk);
        user_we   = 1'b0;
    endtask

    task automatic inject(input int idx, input logic dwe, input logic [31:0] d,
                          input logic pwe, input logic [6:0] p);
        error_addr = 9'(idx);
        error_dwe  = dwe;
        error_din  = d;
        error_pwe  = pwe;
        error_pin  = p;
        @(negedge clk);
        error_dwe  = 1'b0;
        error_pwe  = 1'b0;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    task automatic start_core();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; user_addr = '0; user_we = 1'b0; user_din = '0;
        error_dwe = 1'b0; error_pwe = 1'b0; error_din = '0; error_pin = '0; error_addr = '0;
        clear_imem();
        step(2);
        check_eq("reset_pc", pc, 32'h0);
        for (int i = 0; i < 512; i++) user_write(i, 32'h0);
        check_mem("reset_mem0", 0, 32'h0);

        // Basic store
        clear_imem();
        imem[0] = addi(1, 0, 16'd5);
        imem[1] = sw(1, 0, 16'd4);
        start_core(); step(10);
        check_mem("basic_store_m1", 1, 32'd5);

        // Forwarding from EX/MEM and MEM/WB
        clear_imem();
        imem[0] = addi(1, 0, 16'd3);
        imem[1] = rtype(2, 1, 1, 6'b100000);
        imem[2] = rtype(3, 2, 1, 6'b100010);
        imem[3] = sw(2, 0, 16'd0);
        imem[4] = sw(3, 0, 16'd8);
        start_core(); step(12);
        check_mem("fwd_m0", 0, 32'd6);
        check_mem("fwd_m2", 2, 32'd3);

        // Load-use stall: pc must repeat exactly once
        user_write(4, 32'd7);
        clear_imem();
        imem[0] = lw(1, 0, 16'd16);
        imem[1] = rtype(2, 1, 1, 6'b100000);
        imem[2] = sw(2, 0, 16'd20);
        start_core();
        for (int k = 0; k < 6; k++) begin
            step(1);
            check_eq($sformatf("loaduse_pc%0d", k), pc, pc_exp[k]);
        end
        step(8);
        check_mem("loaduse_m5", 5, 32'd14);

        // Single data-bit error corrected on load
        clear_imem();
        imem[0] = addi(4, 0, 16'd2);
        imem[1] = sw(4, 0, 16'd4);
        start_core(); step(10);
        inject(1, 1'b1, 32'd3, 1'b0, 7'd0);
        check_mem("sec_data_user_m1", 1, 32'd2);
        clear_imem();
        imem[0] = lw(5, 0, 16'd4);
        imem[1] = sw(5, 0, 16'd12);
        start_core(); step(10);
        check_mem("sec_data_m3", 3, 32'd2);

        // Single check-bit error leaves data intact
        user_write(8, 32'd9);
        inject(8, 1'b0, 32'd0, 1'b1, tb_encode(32'd9) ^ 7'h04);
        check_mem("sec_chk_user_m8", 8, 32'd9);
        clear_imem();
        imem[0] = lw(6, 0, 16'd32);
        imem[1] = sw(6, 0, 16'd44);
        start_core(); step(10);
        check_mem("sec_chk_m11", 11, 32'd9);

        // Double error halts the core
        user_write(9, 32'd4);
        inject(9, 1'b1, 32'd5, 1'b1, tb_encode(32'd4) ^ 7'h04);
        clear_imem();
        imem[0] = lw(1, 0, 16'd36);
        imem[1] = addi(2, 0, 16'd8);
        imem[2] = addi(3, 0, 16'd1);
        imem[3] = addi(4, 0, 16'd1);
        imem[4] = sw(2, 0, 16'd40);
        start_core(); step(3);
        check_eq("ded_pc_pre", pc, 32'd12);
        step(20);
        check_eq("ded_pc_frozen", pc, 32'd12);
        check_mem("ded_m10", 10, 32'd0);

        // Asynchronous reset mid-run discards the pending store
        clear_imem();
        imem[0] = addi(7, 0, 16'd99);
        imem[6] = sw(7, 0, 16'd48);
        start_core(); step(4);
        #2 rst = 1'b0;
        #1 check_eq("async_reset_pc", pc, 32'h0);
        @(negedge clk);
        clear_imem();
        imem[0] = addi(1, 0, 16'd10);
        imem[1] = addi(2, 0, 16'hFFFD);
        imem[2] = rtype(3, 1, 2, 6'b100000);
        imem[3] = sw(3, 0, 16'd52);
        imem[4] = rtype(4, 2, 1, 6'b100010);
        imem[5] = sw(4, 0, 16'd56);
        rst = 1'b1;
        step(14);
        check_mem("reset_m12_untouched", 12, 32'd0);
        check_mem("fresh_m13", 13, 32'd7);
        check_mem("fresh_m14", 14, 32'hFFFF_FFF3);

        // Same-cycle user write and injection at one address: injection wins
        error_addr = 9'd20; error_din = 32'd55; error_pin = tb_encode(32'd55);
        error_dwe = 1'b1; error_pwe = 1'b1;
        user_write(20, 32'd100);
        error_dwe = 1'b0; error_pwe = 1'b0;
        check_mem("prio_m20", 20, 32'd55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
